layer_out_serializer: RTL and testbench
=======================================

Name: layer_out_serializer

Overview:
Consumes the NN parallel neuron outputs of a layer (per-neuron data slice plus per-neuron valid pulse) and re-emits them as a serial word stream for the next layer's serial input (data + valid), one neuron per beat in neuron order 0..NN-1. It sits between layer N and layer N+1, or after the final layer, where it also reports the argmax index of the frame. Outputs are buffered so layer N may start its next frame while the stream drains; a new frame is refused until the current frame has been sent.

Parameters:
NN, 30, neurons in the producing layer; serial beats per frame
dataWidth, 16, word width; signed two's complement
idxWidth, 5, width of neuron index, must satisfy 2^idxWidth >= NN

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
o_valid  in  NN  per-neuron output-valid pulse from producing layer
x_out  in  NN*dataWidth  neuron i value at [i*dataWidth +: dataWidth]
out_ready  in  1  downstream may accept a beat this cycle
clr_err  in  1  synchronous clear of overrun
data_out  out  dataWidth  serial word, registered
data_valid  out  1  data_out valid, registered
data_last  out  1  high with the beat carrying neuron NN-1
max_idx  out  idxWidth  argmax of last completed frame, held until next frame ends
busy  out  1  high in SHIFT
overrun  out  1  sticky: an o_valid was dropped

Behaviour:
- Reset (rst=0, async): state=COLLECT, captured=0, idx=0, data_out=0, data_valid=0, data_last=0, max_idx=0, overrun=0, busy=0. Buffer contents are don't-care.
- COLLECT:
  - Each cycle, for every i with o_valid[i]=1 and captured[i]=0: buf[i] <= slice i and captured[i] <= 1.
  - o_valid[i]=1 with captured[i]=1: value ignored (first capture kept) and overrun <= 1.
  - When (captured | o_valid) is all ones, go to SHIFT next edge with idx=0. Simultaneous all-NN valids complete in one cycle.
- SHIFT (busy=1):
  - At each edge with out_ready=1: data_out <= buf[idx], data_valid <= 1, data_last <= (idx==NN-1), idx <= idx+1.
  - At an edge with out_ready=0: data_valid <= 0, data_last <= 0, idx held, data_out held.
  - On the beat where idx==NN-1 is accepted: captured <= 0, idx <= 0, state <= COLLECT, max_idx updated.
  - Any o_valid bit during SHIFT is dropped and sets overrun.
  - o_valid in the first COLLECT cycle after the last beat is captured normally.
- Latency: the last o_valid is sampled at edge E0. With out_ready held high, the first data_valid appears after E1 and NN beats are contiguous. Last beat appears after E(NN).
- Argmax:
  - Running max and index reset at idx=0.
  - Signed compare; strictly-greater replaces, so ties keep the lowest index.
  - max_idx is registered at the last beat.
- Overrun is cleared by clr_err=1 at an edge. If set and clear happen in the same cycle, set wins.
- A reset asserted mid-SHIFT aborts the frame immediately. No partial last beat is emitted after release.
- NN=1: one beat, with data_last and data_valid both high.

Test Plan:
1. Reset then all o_valid=all-ones in one cycle, slice i = i*3, out_ready=1 -> 30 contiguous beats 0,3,...,87 starting two edges later. data_last only on 87. max_idx=29. busy low after.
2. o_valid bits staggered one per cycle in reverse order (29 down to 0) -> SHIFT entered on the edge sampling neuron 0. Output order is still 0..29 with correct values.
3. out_ready toggled 1,0,1,0 during SHIFT -> data_valid follows with one-cycle lag. No beat lost or repeated. 30 beats total.
4. Values with neuron 7 = 16'h7FFF, neuron 12 = 16'h7FFF, others = 16'h8000 (negative) -> max_idx=7.
5. Neuron 4 pulses twice in COLLECT (first 16'h0011, then 16'h0022) -> beat 4 = 16'h0011 and overrun=1. clr_err pulse -> overrun=0. A pulse during SHIFT -> overrun=1 again.
6. rst low at beat 10 of SHIFT -> all outputs zero immediately. After release, a fresh frame streams correctly from neuron 0.

Source files
------------

// File: rtl/layer_out_serializer.sv
// Collects one frame of parallel neuron outputs, then streams them one word per beat
// in neuron order while tracking the signed argmax of the frame.
module layer_out_serializer #(
   parameter int NN        = 30,
   parameter int dataWidth = 16,
   parameter int idxWidth  = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NN-1:0]           o_valid,
   input  logic [NN*dataWidth-1:0] x_out,
   input  logic                    out_ready,
   input  logic                    clr_err,
   output logic [dataWidth-1:0]    data_out,
   output logic                    data_valid,
   output logic                    data_last,
   output logic [idxWidth-1:0]     max_idx,
   output logic                    busy,
   output logic                    overrun
);

   // state   | meaning
   // COLLECT | latching per-neuron values until every neuron has reported
   // SHIFT   | streaming buffered words, one per accepted beat
   typedef enum logic {COLLECT, SHIFT} state_t;

   localparam logic [idxWidth-1:0] LAST_IDX = idxWidth'(NN - 1);

   state_t                       state_q, state_d;
   logic [NN-1:0]                captured;
   logic [dataWidth-1:0]         buf_mem [NN];
   logic [idxWidth-1:0]          idx;
   logic [idxWidth-1:0]          run_idx;
   logic signed [dataWidth-1:0]  run_max;
   logic signed [dataWidth-1:0]  cur_word;
   logic                         all_in;
   logic                         last_beat;
   logic                         new_max;
   logic                         ovr_set;

   assign cur_word  = buf_mem[idx];
   assign all_in    = &(captured | o_valid);
   assign last_beat = (state_q == SHIFT) && out_ready && (idx == LAST_IDX);
   // Strictly greater keeps the lowest index on ties; idx 0 restarts the search.
   assign new_max   = (idx == '0) || (cur_word > run_max);
   assign ovr_set   = (state_q == COLLECT) ? |(o_valid & captured) : |o_valid;
   assign busy      = (state_q == SHIFT);

   always_comb begin
      state_d = state_q;
      case (state_q)
         COLLECT: if (all_in)    state_d = SHIFT;
         SHIFT:   if (last_beat) state_d = COLLECT;
         default:                state_d = COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= COLLECT;
         captured   <= '0;
         idx        <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         data_last  <= 1'b0;
         max_idx    <= '0;
         overrun    <= 1'b0;
         run_max    <= '0;
         run_idx    <= '0;
      end else begin
         state_q <= state_d;
         overrun <= ovr_set | (overrun & ~clr_err);
         if (state_q == COLLECT) begin
            captured   <= captured | o_valid;
            idx        <= '0;
            data_valid <= 1'b0;
            data_last  <= 1'b0;
         end else if (out_ready) begin
            data_out   <= cur_word;
            data_valid <= 1'b1;
            data_last  <= (idx == LAST_IDX);
            if (new_max) begin
               run_max <= cur_word;
               run_idx <= idx;
            end
            if (idx == LAST_IDX) begin
               captured <= '0;
               idx      <= '0;
               max_idx  <= new_max ? idx : run_idx;
            end else begin
               idx <= idx + idxWidth'(1);
            end
         end else begin
            data_valid <= 1'b0;
            data_last  <= 1'b0;
         end
      end
   end

   // Buffer needs no reset: a word is only read after its neuron was captured.
   always_ff @(posedge clk) begin
      if (state_q == COLLECT) begin
         for (int i = 0; i < NN; i++) begin
            if (o_valid[i] && !captured[i])
               buf_mem[i] <= x_out[i*dataWidth +: dataWidth];
         end
      end
   end

endmodule

// File: tb/tb_layer_out_serializer.sv
// Scoreboard bench for layer_out_serializer: a frame-level model predicts beats,
// argmax, busy and overrun; a monitor compares every cycle.
module tb_layer_out_serializer;
   localparam int NN = 30;
   localparam int DW = 16;
   localparam int IW = 5;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [NN-1:0]   o_valid = '0;
   logic [NN*DW-1:0] x_out = '0;
   logic            out_ready = 1'b0;
   logic            clr_err = 1'b0;
   logic [DW-1:0]   data_out;
   logic            data_valid;
   logic            data_last;
   logic [IW-1:0]   max_idx;
   logic            busy;
   logic            overrun;

   layer_out_serializer #(.NN(NN), .dataWidth(DW), .idxWidth(IW)) dut (
      .clk(clk), .rst(rst_n), .o_valid(o_valid), .x_out(x_out),
      .out_ready(out_ready), .clr_err(clr_err), .data_out(data_out),
      .data_valid(data_valid), .data_last(data_last), .max_idx(max_idx),
      .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
      logic [IW-1:0] maxi;
   } beat_t;

   beat_t               exp_q[$];
   logic signed [DW-1:0] m_val [NN];
   logic [NN-1:0]       m_mask = '0;
   logic                m_shf = 1'b0;
   logic                m_ovr = 1'b0;
   int                  m_rem = 0;
   logic                exp_valid = 1'b0;
   logic                exp_busy = 1'b0;
   logic [NN*DW-1:0]    xv = '0;
   int                  tests = 0;
   int                  fails = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Frame-level model: effect of the upcoming rising edge given the applied inputs.
   task automatic model_step();
      logic  set;
      int    best;
      beat_t b;
      if (!rst_n) begin
         m_shf = 1'b0; m_mask = '0; m_ovr = 1'b0; m_rem = 0;
         exp_q.delete(); exp_valid = 1'b0; exp_busy = 1'b0;
         return;
      end
      exp_valid = m_shf && out_ready;
      if (!m_shf) begin
         set = |(o_valid & m_mask);
         for (int i = 0; i < NN; i++)
            if (o_valid[i] && !m_mask[i]) begin
               m_val[i]  = x_out[i*DW +: DW];
               m_mask[i] = 1'b1;
            end
         if (&m_mask) begin
            m_shf = 1'b1;
            m_rem = NN;
            best  = 0;
            for (int i = 1; i < NN; i++)
               if (m_val[i] > m_val[best]) best = i;
            for (int i = 0; i < NN; i++) begin
               b.data = m_val[i];
               b.last = (i == NN - 1);
               b.maxi = IW'(best);
               exp_q.push_back(b);
            end
         end
      end else begin
         set = |o_valid;
         if (out_ready) begin
            m_rem--;
            if (m_rem == 0) begin
               m_shf  = 1'b0;
               m_mask = '0;
            end
         end
      end
      if (set) m_ovr = 1'b1;
      else if (clr_err) m_ovr = 1'b0;
      exp_busy = m_shf;
   endtask

   task automatic tick(input logic [NN-1:0] ov, input logic rdy, input logic clr);
      @(negedge clk);
      o_valid = ov; out_ready = rdy; clr_err = clr; x_out = xv;
      model_step();
   endtask

   // pat: 0 ready always, 1 alternating, 2 random; noise_pct: o_valid noise / clr chance
   task automatic drain(input int pat, input int noise_pct);
      int n = 0;
      logic rdy;
      logic [NN-1:0] ov;
      while (m_shf && n < 400) begin
         rdy = (pat == 0) ? 1'b1 : (pat == 1) ? ((n % 2) == 0) : 1'($urandom_range(0, 1));
         ov = '0;
         if ($urandom_range(0, 99) < noise_pct) ov[$urandom_range(0, NN-1)] = 1'b1;
         tick(ov, rdy, 1'($urandom_range(0, 99) < noise_pct));
         n++;
      end
      if (m_shf) chk("drain_timeout", 32'(1), 32'(0));
      tick('0, 1'b1, 1'b0);
   endtask

   task automatic collect_random(input int dup_pct);
      int n = 0;
      logic [NN-1:0] ov;
      while (!m_shf && n < 300) begin
         ov = '0;
         for (int i = 0; i < NN; i++) begin
            xv[i*DW +: DW] = DW'($urandom);
            if (!m_mask[i] && $urandom_range(0, 3) == 0) ov[i] = 1'b1;
            else if (m_mask[i] && $urandom_range(0, 99) < dup_pct) ov[i] = 1'b1;
         end
         tick(ov, 1'b1, 1'b0);
         n++;
      end
      if (!m_shf) chk("collect_timeout", 32'(1), 32'(0));
   endtask

   initial begin : monitor
      beat_t b;
      forever begin
         @(posedge clk);
         #1;
         chk("data_valid", 32'(data_valid), 32'(exp_valid));
         chk("busy", 32'(busy), 32'(exp_busy));
         chk("overrun", 32'(overrun), 32'(m_ovr));
         if (data_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 32'(1), 32'(0));
            end else begin
               b = exp_q.pop_front();
               chk("data_out", 32'(data_out), 32'(b.data));
               chk("data_last", 32'(data_last), 32'(b.last));
               if (b.last) chk("max_idx", 32'(max_idx), 32'(b.maxi));
            end
         end
      end
   end

   initial begin : driver
      logic [NN-1:0] one_hot;
      tick('0, 1'b1, 1'b0);
      tick('0, 1'b1, 1'b0);
      chk("rst_data_out", 32'(data_out), 32'(0));
      chk("rst_valid", 32'(data_valid), 32'(0));
      chk("rst_last", 32'(data_last), 32'(0));
      chk("rst_max_idx", 32'(max_idx), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_overrun", 32'(overrun), 32'(0));
      rst_n = 1'b1;
      tick('0, 1'b1, 1'b0);

      // 1: all neurons at once, ramp values
      for (int i = 0; i < NN; i++) xv[i*DW +: DW] = DW'(i * 3);
      tick('1, 1'b1, 1'b0);
      drain(0, 0);
      chk("t1_max_idx", 32'(max_idx), 32'(29));
      chk("t1_busy_after", 32'(busy), 32'(0));

      // 2: staggered reverse arrival
      for (int i = 0; i < NN; i++) xv[i*DW +: DW] = DW'($urandom);
      for (int k = NN - 1; k >= 0; k--) begin
         one_hot = '0; one_hot[k] = 1'b1;
         tick(one_hot, 1'b1, 1'b0);
      end
      drain(0, 0);

      // 3: alternating ready
      for (int i = 0; i < NN; i++) xv[i*DW +: DW] = DW'($urandom);
      tick('1, 1'b1, 1'b0);
      drain(1, 0);

      // 4: tie between positive maxima, rest negative
      for (int i = 0; i < NN; i++) xv[i*DW +: DW] = 16'h8000;
      xv[7*DW +: DW] = 16'h7FFF;
      xv[12*DW +: DW] = 16'h7FFF;
      tick('1, 1'b1, 1'b0);
      drain(0, 0);
      chk("t4_max_idx", 32'(max_idx), 32'(7));

      // 5: duplicate pulse, clear, pulse while shifting
      for (int i = 0; i < NN; i++) xv[i*DW +: DW] = DW'(i + 100);
      one_hot = '0; one_hot[4] = 1'b1;
      xv[4*DW +: DW] = 16'h0011;
      tick(one_hot, 1'b1, 1'b0);
      xv[4*DW +: DW] = 16'h0022;
      tick(one_hot, 1'b1, 1'b0);
      tick(~one_hot, 1'b1, 1'b0);
      drain(0, 0);
      chk("t5_overrun_set", 32'(overrun), 32'(1));
      tick('0, 1'b1, 1'b1);
      tick('0, 1'b1, 1'b0);
      chk("t5_overrun_clr", 32'(overrun), 32'(0));
      tick('1, 1'b1, 1'b0);
      one_hot = '0; one_hot[3] = 1'b1;
      tick(one_hot, 1'b1, 1'b0);
      drain(0, 0);
      chk("t5_overrun_shift", 32'(overrun), 32'(1));
      tick('0, 1'b1, 1'b1);

      // 6: reset mid-stream, then a fresh frame
      for (int i = 0; i < NN; i++) xv[i*DW +: DW] = DW'($urandom);
      tick('1, 1'b1, 1'b0);
      for (int k = 0; k < 10; k++) tick('0, 1'b1, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      model_step();
      #1;
      chk("t6_data_out", 32'(data_out), 32'(0));
      chk("t6_valid", 32'(data_valid), 32'(0));
      chk("t6_last", 32'(data_last), 32'(0));
      chk("t6_busy", 32'(busy), 32'(0));
      chk("t6_max_idx", 32'(max_idx), 32'(0));
      tick('0, 1'b1, 1'b0);
      rst_n = 1'b1;
      tick('0, 1'b1, 1'b0);
      for (int i = 0; i < NN; i++) xv[i*DW +: DW] = DW'($urandom);
      tick('1, 1'b1, 1'b0);
      drain(0, 0);

      // randomized frames
      for (int r = 0; r < 25; r++) begin
         collect_random(r % 3 == 0 ? 5 : 0);
         drain(r % 3, r % 2 == 0 ? 0 : 10);
      end

      tick('0, 1'b1, 1'b0);
      tick('0, 1'b1, 1'b0);
      chk("queue_empty", 32'(exp_q.size()), 32'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
